// File: rtl/doc_wave_fetch.sv
// DOC5503 wave-data feeder: byte reads served from a one-word cache or an SDRAM word fetch,
// with a one-entry pending slot for reads arriving while busy and GLU write snooping.
module doc_wave_fetch #(
  parameter int          MEM_ADDR_WIDTH = 21,
  parameter logic [6:0]  MEM_BASE       = 7'h04,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  TIMEOUT_BYTE   = 8'h80
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      wave_rd_i,
  input  logic [15:0]               wave_addr_i,
  output logic [7:0]                wave_data_o,
  output logic                      wave_data_ready_o,
  input  logic                      glu_wr_i,
  input  logic [15:0]               glu_wr_addr_i,
  output logic                      mem_rd_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                      mem_ready_i,
  input  logic [31:0]               mem_q_i,
  output logic                      overflow_o,
  output logic                      timeout_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;

  logic [31:0]   cache_q;
  logic [13:0]   cache_tag_q;
  logic          cache_vld_q;
  logic [13:0]   fetch_tag_q;
  logic [1:0]    fetch_off_q;
  logic          suppress_q;
  logic          pend_vld_q;
  logic [15:0]   pend_addr_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q;
  logic [7:0]    data_q;
  logic          overflow_q, timeout_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;

  logic        idle_free, use_pend, req_go, hit, miss, fill, tmo;
  logic        snoop_cache, snoop_fetch, snoop_req;
  logic [15:0] req_addr;
  logic [13:0] req_tag;

  // The strobe cycle still counts as busy so a pending request is served one cycle later.
  assign idle_free   = (state_q == IDLE) && !ready_q;
  assign use_pend    = idle_free && pend_vld_q;
  assign req_go      = idle_free && (pend_vld_q || wave_rd_i);
  assign req_addr    = use_pend ? pend_addr_q : wave_addr_i;
  assign req_tag     = req_addr[15:2];
  assign snoop_cache = glu_wr_i && (glu_wr_addr_i[15:2] == cache_tag_q);
  assign snoop_fetch = glu_wr_i && (glu_wr_addr_i[15:2] == fetch_tag_q);
  assign snoop_req   = glu_wr_i && (glu_wr_addr_i[15:2] == req_tag);
  assign hit         = req_go && cache_vld_q && (req_tag == cache_tag_q) && !snoop_cache;
  assign miss        = req_go && !hit;
  assign fill        = (state_q == WAIT) && mem_ready_i;
  assign tmo         = (state_q == WAIT) && !mem_ready_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    mem_rd_o = 1'b0;
    case (state_q)
      IDLE:  if (miss) state_d = ISSUE;
      ISSUE: begin
        mem_rd_o = 1'b1;
        state_d  = WAIT;
      end
      WAIT:  if (fill || tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cache_q     <= '0;
      cache_tag_q <= '0;
      cache_vld_q <= 1'b0;
      fetch_tag_q <= '0;
      fetch_off_q <= '0;
      suppress_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      ready_q <= hit || fill || tmo;
      if (hit)       data_q <= cache_q[{req_addr[1:0], 3'b000} +: 8];
      else if (fill) data_q <= mem_q_i[{fetch_off_q, 3'b000} +: 8];
      else if (tmo)  data_q <= TIMEOUT_BYTE;

      if (snoop_cache) cache_vld_q <= 1'b0;
      // Invalidate on miss so a timed-out fetch leaves nothing stale behind.
      if (miss) begin
        cache_vld_q <= 1'b0;
        fetch_tag_q <= req_tag;
        fetch_off_q <= req_addr[1:0];
        suppress_q  <= snoop_req;
        mem_addr_q  <= MEM_ADDR_WIDTH'({MEM_BASE, req_tag});
      end else if (state_q != IDLE && snoop_fetch) begin
        suppress_q <= 1'b1;
      end
      if (fill) begin
        cache_q     <= mem_q_i;
        cache_tag_q <= fetch_tag_q;
        cache_vld_q <= !(suppress_q || snoop_fetch);
      end

      if (state_q == ISSUE)     cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;

      if (wave_rd_i && !idle_free) begin
        pend_vld_q  <= 1'b1;
        pend_addr_q <= wave_addr_i;
        if (pend_vld_q) overflow_q <= 1'b1;
      end else if (use_pend) begin
        pend_vld_q <= wave_rd_i;
        if (wave_rd_i) pend_addr_q <= wave_addr_i;
      end

      if (tmo) timeout_q <= 1'b1;
    end
  end

  assign wave_data_o       = data_q;
  assign wave_data_ready_o = ready_q;
  assign mem_addr_o        = mem_addr_q;
  assign overflow_o        = overflow_q;
  assign timeout_o         = timeout_q;
endmodule

// File: tb/tb_doc_wave_fetch.sv
// Directed bench for doc_wave_fetch: miss, hit, snoop, busy/overflow, timeout, reset mid-fetch.
module tb_doc_wave_fetch;
  localparam int AW = 21;
  localparam int T  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          wave_rd = 1'b0;
  logic [15:0]   wave_addr = '0;
  logic [7:0]    wave_data;
  logic          wave_ready;
  logic          glu_wr = 1'b0;
  logic [15:0]   glu_addr = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_ready = 1'b0;
  logic [31:0]   mem_q = '0;
  logic          overflow, timeout;

  int n_cmp = 0;
  int n_err = 0;
  int strobes = 0;
  int mem_rds = 0;
  int s0, m0, k;

  doc_wave_fetch #(.MEM_ADDR_WIDTH(AW), .MEM_BASE(7'h04), .TIMEOUT_CYCLES(T),
                   .TIMEOUT_BYTE(8'h80)) dut (
    .clk_i(clk), .reset_i(rst), .wave_rd_i(wave_rd), .wave_addr_i(wave_addr),
    .wave_data_o(wave_data), .wave_data_ready_o(wave_ready), .glu_wr_i(glu_wr),
    .glu_wr_addr_i(glu_addr), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
    .mem_ready_i(mem_ready), .mem_q_i(mem_q), .overflow_o(overflow), .timeout_o(timeout));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wave_ready) strobes++;
    if (mem_rd) mem_rds++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for mem_rd, returns the word lat cycles later; ends on the strobe cycle.
  task automatic respond(input string tag, input logic [31:0] q, input int lat);
    int i;
    for (i = 0; i < 10 && !mem_rd; i++) step();
    chk({tag, "_mem_rd_seen"}, 32'(mem_rd), 32'd1);
    step(lat);
    mem_ready = 1'b1;
    mem_q     = q;
    step();
    mem_ready = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    wave_rd   = 1'b1;
    wave_addr = a;
    step();
    wave_rd   = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step(3);
    chk("rst_ready", 32'(wave_ready), 0);
    chk("rst_data", 32'(wave_data), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_flags", {30'd0, overflow, timeout}, 0);
    rst = 1'b0;
    step(2);

    // Miss at 16'h1235, SDRAM answers 5 cycles after mem_rd
    s0 = strobes;
    rd(16'h1235);
    chk("miss_mem_rd", 32'(mem_rd), 1);
    chk("miss_mem_addr", 32'(mem_addr), 32'h0001048D);
    step();
    chk("miss_mem_rd_once", 32'(mem_rd), 0);
    step(4);
    chk("miss_no_early_strobe", strobes - s0, 0);
    mem_ready = 1'b1;
    mem_q     = 32'hDDCCBBAA;
    step();
    mem_ready = 1'b0;
    chk("miss_strobe_c7", 32'(wave_ready), 1);
    chk("miss_data", 32'(wave_data), 32'hBB);
    step();
    chk("miss_strobe_one", 32'(wave_ready), 0);

    // Hit
    m0 = mem_rds;
    rd(16'h1236);
    chk("hit_strobe", 32'(wave_ready), 1);
    chk("hit_data", 32'(wave_data), 32'hCC);
    chk("hit_no_mem_rd", mem_rds - m0, 0);

    // Non-matching GLU write keeps the word cached
    glu_wr = 1'b1; glu_addr = 16'h1238;
    step();
    glu_wr = 1'b0;
    rd(16'h1234);
    chk("snoop_nomatch_hit", 32'(wave_ready), 1);
    chk("snoop_nomatch_data", 32'(wave_data), 32'hAA);
    chk("snoop_nomatch_no_rd", mem_rds - m0, 0);
    step();

    // Matching GLU write invalidates; refetch returns new data, which is cached again
    glu_wr = 1'b1; glu_addr = 16'h1234;
    step();
    glu_wr = 1'b0;
    rd(16'h1237);
    chk("snoop_match_mem_rd", 32'(mem_rd), 1);
    respond("snoop", 32'h11223344, 2);
    chk("snoop_refetch_data", {23'd0, wave_ready, wave_data}, 32'h111);
    step();
    m0 = mem_rds;
    rd(16'h1236);
    chk("refill_hit_data", {23'd0, wave_ready, wave_data}, 32'h122);
    chk("refill_no_rd", mem_rds - m0, 0);
    step();

    // Busy: A miss, B in ISSUE, C in WAIT overwrites B
    s0 = strobes; m0 = mem_rds;
    rd(16'h2000);
    rd(16'h3001);
    rd(16'h4002);
    chk("busy_overflow", 32'(overflow), 1);
    mem_ready = 1'b1; mem_q = 32'hA3A2A1A0;
    step();
    mem_ready = 1'b0;
    chk("busy_a_data", {23'd0, wave_ready, wave_data}, 32'h1A0);
    respond("busy_c", 32'hC3C2C1C0, 2);
    chk("busy_c_data", {23'd0, wave_ready, wave_data}, 32'h1C2);
    chk("busy_c_addr", 32'(mem_addr), 32'h00011000);
    step(5);
    chk("busy_two_strobes", strobes - s0, 2);
    chk("busy_two_reads", mem_rds - m0, 2);

    // Timeout
    chk("pre_timeout_flag", 32'(timeout), 0);
    rd(16'h5003);
    for (k = 1; k < 100 && !wave_ready; k++) step();
    chk("timeout_latency", k, T + 2);
    chk("timeout_data", 32'(wave_data), 32'h80);
    chk("timeout_flag", 32'(timeout), 1);
    step();
    s0 = strobes;
    mem_ready = 1'b1; mem_q = 32'hFFFFFFFF;
    step();
    mem_ready = 1'b0;
    step(2);
    chk("late_ready_ignored", strobes - s0, 0);
    m0 = mem_rds;
    rd(16'h5003);
    chk("after_timeout_miss", 32'(mem_rd), 1);
    respond("after_timeout", 32'h0F0E0D0C, 1);
    chk("after_timeout_data", {23'd0, wave_ready, wave_data}, 32'h10F);
    chk("timeout_sticky", 32'(timeout), 1);
    step();

    // Reset during WAIT with a pending request queued
    rd(16'h6000);
    step();
    rd(16'h7000);
    rst = 1'b1;
    step();
    chk("rst_wait_outputs", {27'd0, wave_ready, mem_rd, overflow, timeout, |wave_data}, 0);
    rst = 1'b0;
    s0 = strobes; m0 = mem_rds;
    mem_ready = 1'b1; mem_q = 32'h12345678;
    step();
    mem_ready = 1'b0;
    step(4);
    chk("rst_no_strobe", strobes - s0, 0);
    chk("rst_pending_dropped", mem_rds - m0, 0);
    rd(16'h1235);
    chk("rst_then_miss", 32'(mem_rd), 1);
    respond("rst_refetch", 32'h44332211, 3);
    chk("rst_refetch_data", {23'd0, wave_ready, wave_data}, 32'h122);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
